seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Consumes the four 8-bit segment buses (seg0..seg3) produced by the game top level and drives a 4-digit, common-anode, multiplexed 7-segment display.
- Time-multiplexes one digit at a time with an inter-digit blanking gap to prevent ghosting.
- Latches all four digits atomically once per frame so the display never shows a partial update.
- Supports per-digit blinking gated by the 1 Hz game clock level.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- DIGIT_HZ, 1000, per-digit slot rate. Slot length DIV = CLK_HZ/DIGIT_HZ cycles (integer division).
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off. Legal range is 1 <= BLANK_CYCLES < DIV.

Ports:
- Clk100M  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- seg0  in  8  digit 0 pattern {dp,g,f,e,d,c,b,a}; 1 = segment lit.
- seg1  in  8  digit 1 pattern, same encoding.
- seg2  in  8  digit 2 pattern, same encoding.
- seg3  in  8  digit 3 pattern, same encoding.
- blinkMask  in  4  bit i = 1 enables blinking of digit i.
- Clk1Hz  in  1  blink phase level, sampled at each frame boundary.
- an  out  4  anode enables, active-low; an[i] = 0 lights digit i.
- cat  out  8  cathodes {dp,g..a}, active-low.
- frameStart  out  1  one-cycle pulse marking each frame boundary.

Behaviour:
- Counters:
  - slotCnt counts 0..DIV-1. On DIV-1 it wraps to 0 and digitIdx increments modulo 4 (3 -> 0).
  - Counter widths are derived from DIV with $clog2.
- Phases within a slot:
  - BLANK when slotCnt < BLANK_CYCLES.
  - DRIVE otherwise.
- Frame boundary: the cycle with slotCnt == 0 and digitIdx == 0. In that cycle:
  - shadow[0..3] <= seg0..seg3.
  - blinkPh <= Clk1Hz.
  - This cycle always falls in BLANK, so a shadow update is never visible mid-digit.
- Output registers (1-cycle latency from counter state):
  - BLANK: an = 4'b1111, cat = 8'hFF.
  - DRIVE: an = ~(4'b0001 << digitIdx).
  - DRIVE: cat = 8'hFF if blinkMask[digitIdx] & ~blinkPh, else ~shadow[digitIdx].
  - blinkMask is sampled live; blinkPh is held per frame.
- frameStart:
  - Registered; high exactly one cycle, in the cycle after each frame boundary.
  - Period is 4*DIV cycles.
- Reset (reset == 0 at a clock edge):
  - slotCnt = 0, digitIdx = 0, shadow = 0, blinkPh = 0.
  - an = 4'b1111, cat = 8'hFF, frameStart = 0.
- Reset release: the first cycle with reset == 1 is a frame boundary.
  - The inputs are latched in that cycle.
  - frameStart = 1 on the following cycle.
- Reset mid-operation: takes effect on the next edge regardless of phase. The outputs blank and the scan restarts at digit 0 with no partial slot.
- Invariants:
  - At most one anode is active at any cycle; an is always one of 1111, 1110, 1101, 1011, 0111.
  - Every transition between two different active anodes passes through at least BLANK_CYCLES cycles of 1111.
- Input changes outside the frame-boundary cycle have no effect on the display until the next frame.

Test Plan (bench parameters: CLK_HZ=100, DIGIT_HZ=10, hence DIV=10; BLANK_CYCLES=2; frame = 40 cycles):
- Reset: hold reset=0 for 5 cycles -> an=1111, cat=FF, frameStart=0 throughout. Release -> frameStart=1 on the second cycle after release, then exactly every 40 cycles.
- Scan order: seg0=3F, seg1=06, seg2=5B, seg3=4F, blinkMask=0.
  - Required sequence per slot: 2 cycles an=1111/cat=FF, then 8 cycles of the driven digit.
  - Driven digits in order: an=1110/cat=C0, an=1101/cat=F9, an=1011/cat=A4, an=0111/cat=B0, then repeat.
- Atomic latch: change seg2 from 5B to 66 during digit 1's DRIVE phase.
  - The digit-2 slot of the current frame still shows cat=A4.
  - The next frame shows cat=99.
- Blink: blinkMask=0100.
  - Clk1Hz=0 at the boundary -> digit-2 DRIVE shows an=1011, cat=FF; digits 0, 1 and 3 are normal.
  - Clk1Hz=1 at the next boundary -> digit 2 shows cat=A4.
  - Toggling Clk1Hz mid-frame has no effect.
- Reset mid-operation: assert reset for 1 cycle during digit 2 DRIVE.
  - Next cycle: an=1111, cat=FF.
  - After release the scan restarts at digit 0 with freshly latched inputs, and frameStart pulses.
- Continuous assertion over a 2000-cycle random-input run:
  - an is always a legal one-hot-low value or 1111.
  - Every change between two different active anodes is separated by at least 2 cycles of an=1111.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment scanner.
// Per-frame atomic latch, per-digit blanking gap and blink gating.
module seg_scan_driver #(
    parameter int CLK_HZ       = 100000000,
    parameter int DIGIT_HZ     = 1000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       Clk100M,
    input  logic       reset,
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    input  logic [7:0] seg3,
    input  logic [3:0] blinkMask,
    input  logic       Clk1Hz,
    output logic [3:0] an,
    output logic [7:0] cat,
    output logic       frameStart
);

    localparam int DIV = CLK_HZ / DIGIT_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

    logic [CW-1:0] r_slot;
    logic [1:0]    r_digit;
    logic [7:0]    r_shadow [4];
    logic          r_blinkPh;

    logic          w_slotLast;
    logic          w_boundary;
    logic          w_blank;
    logic          w_blinkOff;
    logic [7:0]    w_curSeg;

    assign w_slotLast = (r_slot == SLOT_LAST);
    assign w_boundary = (r_slot == '0) && (r_digit == 2'd0);
    assign w_blank    = (r_slot < BLANK_LIM);
    assign w_curSeg   = r_shadow[r_digit];
    // blinkMask is live; the phase is frozen for the whole frame
    assign w_blinkOff = blinkMask[r_digit] & ~r_blinkPh;

    always_ff @(posedge Clk100M) begin
        if (!reset) begin
            r_slot     <= '0;
            r_digit    <= 2'd0;
            r_shadow   <= '{default: 8'h00};
            r_blinkPh  <= 1'b0;
            an         <= 4'hF;
            cat        <= 8'hFF;
            frameStart <= 1'b0;
        end else begin
            r_slot <= w_slotLast ? '0 : r_slot + 1'b1;
            if (w_slotLast) begin
                r_digit <= r_digit + 2'd1;
            end
            // boundary is always inside BLANK, so shadow never changes mid-digit
            if (w_boundary) begin
                r_shadow[0] <= seg0;
                r_shadow[1] <= seg1;
                r_shadow[2] <= seg2;
                r_shadow[3] <= seg3;
                r_blinkPh   <= Clk1Hz;
            end
            frameStart <= w_boundary;
            if (w_blank) begin
                an  <= 4'hF;
                cat <= 8'hFF;
            end else begin
                an  <= ~(4'b0001 << r_digit);
                cat <= w_blinkOff ? 8'hFF : ~w_curSeg;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: table-driven frames plus a random run
// against a frame-position reference model.
module tb_seg_scan_driver;

    logic       Clk100M = 1'b0;
    logic       reset;
    logic [7:0] seg0, seg1, seg2, seg3;
    logic [3:0] blinkMask;
    logic       Clk1Hz;
    logic [3:0] an;
    logic [7:0] cat;
    logic       frameStart;

    seg_scan_driver #(
        .CLK_HZ      (100),
        .DIGIT_HZ    (10),
        .BLANK_CYCLES(2)
    ) dut (
        .Clk100M   (Clk100M),
        .reset     (reset),
        .seg0      (seg0),
        .seg1      (seg1),
        .seg2      (seg2),
        .seg3      (seg3),
        .blinkMask (blinkMask),
        .Clk1Hz    (Clk1Hz),
        .an        (an),
        .cat       (cat),
        .frameStart(frameStart)
    );

    always #5 Clk100M = ~Clk100M;

    typedef struct {
        logic [3:0] an;
        logic [7:0] cat;
    } vec_t;

    vec_t tbl [4];

    int total = 0;
    int bad   = 0;

    // reference model: position of the next edge within a 40-cycle frame
    int         m_pos = 0;
    logic [7:0] m_sh [4];
    logic       m_bph = 1'b0;

    bit         mon_en = 1'b0;
    logic [3:0] last_act = 4'hF;
    int         gap = 100;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        logic [3:0] e_an;
        logic [7:0] e_cat;
        logic       e_fs;
        int         p, d, sl;
        e_an  = 4'hF;
        e_cat = 8'hFF;
        e_fs  = 1'b0;
        if (!reset) begin
            m_pos = 0;
            m_sh  = '{default: 8'h00};
            m_bph = 1'b0;
        end else begin
            p = m_pos;
            if (p == 0) begin
                m_sh[0] = seg0;
                m_sh[1] = seg1;
                m_sh[2] = seg2;
                m_sh[3] = seg3;
                m_bph   = Clk1Hz;
            end
            d    = p / 10;
            sl   = p % 10;
            e_fs = (p == 0);
            if (sl >= 2) begin
                e_an[d] = 1'b0;
                e_cat   = (blinkMask[d] && !m_bph) ? 8'hFF : ~m_sh[d];
            end
            m_pos = (p + 1) % 40;
        end
        @(posedge Clk100M);
        @(negedge Clk100M);
        chk("model_an", {4'h0, an}, {4'h0, e_an});
        chk("model_cat", cat, e_cat);
        chk("model_fs", {7'h0, frameStart}, {7'h0, e_fs});
    endtask

    // one 40-cycle frame checked against the constant table
    task automatic frame(input logic [3:0] bl, input int mut);
        logic [3:0] x_an;
        logic [7:0] x_cat;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 10; c++) begin
                if (mut == 1 && s == 1 && c == 5) seg2 = 8'h66;
                if (mut == 2 && s == 1 && c == 5) Clk1Hz = ~Clk1Hz;
                cyc();
                x_an  = (c < 2) ? 4'hF : tbl[s].an;
                x_cat = (c < 2 || bl[s]) ? 8'hFF : tbl[s].cat;
                chk("tbl_an", {4'h0, an}, {4'h0, x_an});
                chk("tbl_cat", cat, x_cat);
                chk("tbl_fs", {7'h0, frameStart},
                    {7'h0, (s == 0 && c == 0)});
            end
        end
    endtask

    always @(negedge Clk100M) begin
        if (mon_en) begin
            total++;
            if (!(an inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) begin
                bad++;
                $display("FAIL an_legal got=%b t=%0t", an, $time);
            end
            if (an != 4'hF) begin
                if (last_act != 4'hF && an != last_act) begin
                    total++;
                    if (gap < 2) begin
                        bad++;
                        $display("FAIL blank_gap got=%0d want>=2 t=%0t",
                                 gap, $time);
                    end
                end
                last_act = an;
                gap = 0;
            end else begin
                gap++;
            end
        end
    end

    initial begin
        reset     = 1'b0;
        seg0      = 8'h3F;
        seg1      = 8'h06;
        seg2      = 8'h5B;
        seg3      = 8'h4F;
        blinkMask = 4'h0;
        Clk1Hz    = 1'b1;
        tbl[0] = '{4'hE, 8'hC0};
        tbl[1] = '{4'hD, 8'hF9};
        tbl[2] = '{4'hB, 8'hA4};
        tbl[3] = '{4'h7, 8'hB0};

        repeat (5) begin
            cyc();
            chk("rst_an", {4'h0, an}, 8'h0F);
            chk("rst_cat", cat, 8'hFF);
            chk("rst_fs", {7'h0, frameStart}, 8'h00);
        end
        mon_en = 1'b1;

        reset = 1'b1;
        frame(4'b0000, 0);
        frame(4'b0000, 1);
        tbl[2].cat = 8'h99;
        frame(4'b0000, 0);

        seg2       = 8'h5B;
        tbl[2].cat = 8'hA4;
        blinkMask  = 4'b0100;
        Clk1Hz     = 1'b0;
        frame(4'b0100, 2);
        frame(4'b0000, 2);

        repeat (25) cyc();
        reset     = 1'b0;
        seg0      = 8'h6D;
        seg1      = 8'h7D;
        seg2      = 8'h07;
        seg3      = 8'h7F;
        blinkMask = 4'h0;
        cyc();
        chk("mid_rst_an", {4'h0, an}, 8'h0F);
        chk("mid_rst_cat", cat, 8'hFF);
        reset = 1'b1;
        tbl[0] = '{4'hE, 8'h92};
        tbl[1] = '{4'hD, 8'h82};
        tbl[2] = '{4'hB, 8'hF8};
        tbl[3] = '{4'h7, 8'h80};
        frame(4'b0000, 0);

        for (int i = 0; i < 2000; i++) begin
            reset     = ($urandom_range(0, 199) != 0);
            seg0      = 8'($urandom);
            seg1      = 8'($urandom);
            seg2      = 8'($urandom);
            seg3      = 8'($urandom);
            blinkMask = 4'($urandom);
            Clk1Hz    = 1'($urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
